clock_divider_multi: RTL and testbench
======================================

Name: clock_divider_multi

Overview:
- Parametrised, multi-channel successor to the fixed divide-by-16 peripheral clock divider.
- Each channel produces a 50%-duty divided clock from clkin, with a half-period that can be reprogrammed at runtime, a per-channel enable, and a one-cycle tick strobe.
- New divisor values are staged and applied only at a toggle boundary, so no runt pulses occur.
- Sits in the peripheral block and feeds slow clocks or strobes to timers, the UART baud logic and display scanning.

Parameters:
- CHANNELS, 2, number of independent divider channels (1..8).
- WIDTH, 16, width of the half-period counter and divisor registers.
- CHAN_W, 1, width of wr_chan; must satisfy 2^CHAN_W >= CHANNELS.
- DEFAULT_HALF, 8, half-period loaded at reset for every channel (8 gives divide-by-16).

Ports:
- clkin  input  1  system clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- ch_enable  input  CHANNELS  per-channel run enable (level).
- wr_en  input  1  one-cycle write strobe for a new half-period.
- wr_chan  input  CHAN_W  target channel index for the write.
- wr_half  input  WIDTH  new half-period, in clkin cycles.
- clkout  output  CHANNELS  divided clock per channel, registered.
- tick  output  CHANNELS  one-cycle strobe per channel, asserted in the first cycle clkout is high.
- pending  output  CHANNELS  staged write not yet applied.

Behaviour:
- Reset (reset=0, asynchronous), per channel:
  - half = DEFAULT_HALF, cnt = 0, clkout = 0, tick = 0, pending = 0, staged value = 0.
- Per-channel state:
  - half register H, counter cnt (WIDTH bits), clkout register, pending flag, staged register.
- H = 0 (from a write or from DEFAULT_HALF) is treated as 1. This gives the minimum output period of 2 clkin cycles.
- Running (ch_enable[c] = 1):
  - cnt counts 0..H-1.
  - Boundary = (cnt == H-1). At a boundary: cnt <= 0 and clkout <= ~clkout; otherwise cnt <= cnt + 1.
  - Output period = 2*H clkin cycles, duty 50%.
- tick[c] <= boundary & ~clkout & ch_enable. tick is therefore high exactly in the first cycle that clkout is high; otherwise it is 0.
- Write (wr_en = 1, wr_chan = c < CHANNELS):
  - staged[c] <= wr_half, pending[c] <= 1.
  - A second write before application overwrites the staged value; the last write wins.
  - wr_chan >= CHANNELS: write ignored, no state change.
- Application of a staged value while running:
  - At the next boundary of that channel: H <= staged, pending <= 0.
  - The new H governs the half-period that starts at that boundary.
- Write in the same cycle as a boundary: wr_half bypasses staging and is applied at that boundary; pending stays 0.
- Disabled (ch_enable[c] = 0), at the next edge:
  - cnt <= 0, clkout <= 0, tick <= 0.
  - Any pending value is applied to H (H <= staged, pending <= 0).
  - A write while disabled is applied on the following edge; pending is high for one cycle.
- Enable rising edge: counting starts from cnt = 0. The first clkout rise and tick occur H cycles after the first enabled edge.
- Mid-operation reset: all channels return to the reset values immediately; staged writes are lost.
- Channels are fully independent; there is no phase alignment between them.

Test Plan:
- Reset, then ch_enable = 2'b11, no writes -> both clkout have period 16 cycles. The first rise is 8 cycles after enable. tick is high for 1 cycle at each rise.
- Write wr_chan = 0, wr_half = 3 mid half-period -> pending[0] = 1 until the next ch0 toggle, then ch0 period = 6. ch1 is unchanged at 16.
- Two writes to ch1 (5 then 2) before its boundary -> only 2 is applied; ch1 period becomes 4; pending[1] clears at the boundary.
- Write wr_half = 0 to ch0 -> period 2 (clkout toggles every cycle); tick every 2 cycles.
- Write coinciding exactly with a ch0 boundary cycle -> the new value is applied at that boundary and pending[0] is never seen high.
- Drop ch_enable[0] while clkout[0] = 1 -> clkout[0] = 0 on the next edge. Re-enable -> first rise H cycles later. Assert reset mid-count -> all outputs 0 and H = 8 immediately.

Source files
------------

// File: rtl/clock_divider_multi.sv
// clock_divider_multi
//   Multi-channel 50%-duty clock divider for the peripheral block. Each
//   channel toggles its divided clock every H clkin cycles, where H is the
//   half-period. A half-period of 0 behaves as 1. A new half-period written
//   at runtime is staged and takes effect only at a toggle boundary, so the
//   divided clock never produces a runt pulse.
//
// Ports
//   clkin      system clock, all state changes on its rising edge
//   reset      asynchronous active-low reset
//   ch_enable  per-channel run enable (level)
//   wr_en      one-cycle write strobe for a new half-period
//   wr_chan    channel targeted by the write (out-of-range index ignored)
//   wr_half    new half-period in clkin cycles
//   clkout     registered divided clock per channel
//   tick       one-cycle strobe in the first cycle clkout is high
//   pending    a staged half-period is waiting to be applied

module clock_divider_multi #(
    parameter int CHANNELS     = 2,
    parameter int WIDTH        = 16,
    parameter int CHAN_W       = 1,
    parameter int DEFAULT_HALF = 8
) (
    input  logic                clkin,
    input  logic                reset,
    input  logic [CHANNELS-1:0] ch_enable,
    input  logic                wr_en,
    input  logic [CHAN_W-1:0]   wr_chan,
    input  logic [WIDTH-1:0]    wr_half,
    output logic [CHANNELS-1:0] clkout,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    localparam logic [WIDTH-1:0] HALF_RST = WIDTH'(DEFAULT_HALF);

    logic [WIDTH-1:0]    half_q  [CHANNELS];
    logic [WIDTH-1:0]    half_d  [CHANNELS];
    logic [WIDTH-1:0]    cnt_q   [CHANNELS];
    logic [WIDTH-1:0]    cnt_d   [CHANNELS];
    logic [WIDTH-1:0]    stage_q [CHANNELS];
    logic [WIDTH-1:0]    stage_d [CHANNELS];
    logic [CHANNELS-1:0] clkout_q, clkout_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] pending_q, pending_d;

    logic [WIDTH-1:0]    last_cnt [CHANNELS];
    logic [CHANNELS-1:0] boundary;
    logic [CHANNELS-1:0] wr_hit;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            // H = 0 runs as H = 1, so the terminal count is 0 in both cases.
            last_cnt[c] = (half_q[c] == '0) ? '0 : half_q[c] - WIDTH'(1);
            boundary[c] = ch_enable[c] && (cnt_q[c] == last_cnt[c]);
            // Indices at or above CHANNELS match no channel and are dropped.
            wr_hit[c]   = wr_en && (wr_chan == CHAN_W'(c));
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            half_d[c]    = half_q[c];
            cnt_d[c]     = cnt_q[c];
            stage_d[c]   = stage_q[c];
            clkout_d[c]  = clkout_q[c];
            tick_d[c]    = 1'b0;
            pending_d[c] = pending_q[c];

            if (!ch_enable[c]) begin
                cnt_d[c]    = '0;
                clkout_d[c] = 1'b0;
                // Idle channel: flush any staged value straight into H.
                // A write arriving now is staged and flushed next edge.
                if (pending_q[c]) begin
                    half_d[c]    = stage_q[c];
                    pending_d[c] = 1'b0;
                end
                if (wr_hit[c]) begin
                    stage_d[c]   = wr_half;
                    pending_d[c] = 1'b1;
                end
            end else if (boundary[c]) begin
                cnt_d[c]     = '0;
                clkout_d[c]  = ~clkout_q[c];
                tick_d[c]    = ~clkout_q[c];
                pending_d[c] = 1'b0;
                // A write landing on the boundary itself skips staging.
                if (wr_hit[c]) begin
                    half_d[c] = wr_half;
                end else if (pending_q[c]) begin
                    half_d[c] = stage_q[c];
                end
            end else begin
                cnt_d[c] = cnt_q[c] + WIDTH'(1);
                if (wr_hit[c]) begin
                    stage_d[c]   = wr_half;
                    pending_d[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                half_q[c]  <= HALF_RST;
                cnt_q[c]   <= '0;
                stage_q[c] <= '0;
            end
            clkout_q  <= '0;
            tick_q    <= '0;
            pending_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                half_q[c]  <= half_d[c];
                cnt_q[c]   <= cnt_d[c];
                stage_q[c] <= stage_d[c];
            end
            clkout_q  <= clkout_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
        end
    end

    assign clkout  = clkout_q;
    assign tick    = tick_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
module tb_clock_divider_multi;

    localparam int CH = 2;
    localparam int W  = 16;
    localparam int CW = 1;

    logic          clkin;
    logic          reset;
    logic [CH-1:0] ch_enable;
    logic          wr_en;
    logic [CW-1:0] wr_chan;
    logic [W-1:0]  wr_half;
    logic [CH-1:0] clkout;
    logic [CH-1:0] tick;
    logic [CH-1:0] pending;

    clock_divider_multi #(
        .CHANNELS(CH), .WIDTH(W), .CHAN_W(CW), .DEFAULT_HALF(8)
    ) dut (
        .clkin(clkin), .reset(reset), .ch_enable(ch_enable),
        .wr_en(wr_en), .wr_chan(wr_chan), .wr_half(wr_half),
        .clkout(clkout), .tick(tick), .pending(pending)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: a remaining-cycles countdown per channel.
    int m_h    [CH];
    int m_rem  [CH];
    int m_stg  [CH];
    bit m_clk  [CH];
    bit m_tick [CH];
    bit m_pend [CH];
    logic [3*CH-1:0] exp_q [$];

    function automatic int eff(input int h);
        return (h == 0) ? 1 : h;
    endfunction

    always @(posedge clkin) begin
        logic [3*CH-1:0] e;
        cyc++;
        for (int c = 0; c < CH; c++) begin
            bit hit;
            hit = wr_en && (int'(wr_chan) == c);
            if (!reset) begin
                m_h[c] = 8; m_stg[c] = 0; m_pend[c] = 0;
                m_clk[c] = 0; m_tick[c] = 0; m_rem[c] = 7;
            end else if (ch_enable[c]) begin
                if (m_rem[c] == 0) begin
                    m_tick[c] = !m_clk[c];
                    m_clk[c]  = !m_clk[c];
                    if (hit) begin
                        m_h[c] = int'(wr_half); m_pend[c] = 0;
                    end else if (m_pend[c]) begin
                        m_h[c] = m_stg[c]; m_pend[c] = 0;
                    end
                    m_rem[c] = eff(m_h[c]) - 1;
                end else begin
                    m_rem[c]--;
                    m_tick[c] = 0;
                    if (hit) begin
                        m_stg[c] = int'(wr_half); m_pend[c] = 1;
                    end
                end
            end else begin
                m_clk[c] = 0; m_tick[c] = 0;
                if (m_pend[c]) begin
                    m_h[c] = m_stg[c]; m_pend[c] = 0;
                end
                if (hit) begin
                    m_stg[c] = int'(wr_half); m_pend[c] = 1;
                end
                m_rem[c] = eff(m_h[c]) - 1;
            end
        end
        for (int c = 0; c < CH; c++) begin
            e[2*CH + c] = m_clk[c];
            e[CH + c]   = m_tick[c];
            e[c]        = m_pend[c];
        end
        exp_q.push_back(e);
    end

    // Scoreboard pop plus per-channel period measurement.
    int per  [CH];
    int last [CH];
    logic [CH-1:0] prev_clk = '0;

    always @(negedge clkin) begin
        logic [3*CH-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("outputs", int'({clkout, tick, pending}), int'(e));
        end
        for (int c = 0; c < CH; c++) begin
            if (clkout[c] && !prev_clk[c]) begin
                per[c]  = cyc - last[c];
                last[c] = cyc;
            end
        end
        prev_clk = clkout;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic wait_tick(input int c, output int at);
        int n = 0;
        do begin
            @(negedge clkin);
            n++;
        end while (!tick[c] && n < 200);
        chk("tick_seen", int'(tick[c]), 1);
        at = cyc;
    endtask

    task automatic wr(input int c, input int h);
        wr_en   = 1'b1;
        wr_chan = CW'(c);
        wr_half = W'(h);
    endtask

    initial begin
        int t0, at, n;
        reset = 1'b0; ch_enable = '0; wr_en = 1'b0; wr_chan = '0; wr_half = '0;
        for (int c = 0; c < CH; c++) begin per[c] = 0; last[c] = 0; end

        step(3);
        chk("rst_clkout", int'(clkout), 0);
        chk("rst_pending", int'(pending), 0);
        reset = 1'b1;
        step(2);
        chk("idle_clkout", int'(clkout), 0);

        // default divide-by-16 on both channels
        ch_enable = 2'b11; t0 = cyc;
        wait_tick(0, at);
        chk("first_rise_8", at - t0, 8);
        chk("ch1_tick_same", int'(tick[1]), 1);
        step(40);
        chk("per0_16", per[0], 16);
        chk("per1_16", per[1], 16);

        // ch0 half=3 mid half-period
        wait_tick(0, at);
        step(2);
        wr(0, 3); step(1); wr_en = 1'b0;
        chk("pend0_set", int'(pending[0]), 1);
        step(4);
        chk("pend0_held", int'(pending[0]), 1);
        step(1);
        chk("pend0_clear", int'(pending[0]), 0);
        step(30);
        chk("per0_6", per[0], 6);
        chk("per1_still_16", per[1], 16);

        // two writes to ch1, last wins
        wait_tick(1, at);
        wr(1, 5); step(1);
        wr(1, 2); step(1); wr_en = 1'b0;
        chk("pend1_set", int'(pending[1]), 1);
        step(5);
        chk("pend1_held", int'(pending[1]), 1);
        step(1);
        chk("pend1_clear", int'(pending[1]), 0);
        step(40);
        chk("per1_4", per[1], 4);

        // half=0 on ch0 -> period 2
        wait_tick(0, at);
        wr(0, 0); step(1); wr_en = 1'b0;
        chk("pend0_h0", int'(pending[0]), 1);
        step(1);
        chk("pend0_h0_held", int'(pending[0]), 1);
        step(1);
        chk("pend0_h0_clear", int'(pending[0]), 0);
        step(20);
        chk("per0_2", per[0], 2);
        n = 0;
        for (int i = 0; i < 10; i++) begin step(1); n += int'(tick[0]); end
        chk("ticks_in_10", n, 5);

        // write on a boundary cycle (every cycle is one at H=0)
        wr(0, 4); step(1); wr_en = 1'b0;
        chk("pend0_bypass", int'(pending[0]), 0);
        step(30);
        chk("per0_8", per[0], 8);

        // disable while high, write while disabled, re-enable
        wait_tick(0, at);
        ch_enable = 2'b10; step(1);
        chk("dis_clkout0", int'(clkout[0]), 0);
        chk("dis_tick0", int'(tick[0]), 0);
        wr(0, 5); step(1); wr_en = 1'b0;
        chk("dis_pend_1cyc", int'(pending[0]), 1);
        step(1);
        chk("dis_pend_gone", int'(pending[0]), 0);
        ch_enable = 2'b11; t0 = cyc;
        wait_tick(0, at);
        chk("reen_rise_5", at - t0, 5);

        // mid-operation reset drops staged writes
        wait_tick(1, at);
        wr(1, 9); step(1); wr_en = 1'b0;
        chk("pend1_before_rst", int'(pending[1]), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_clkout", int'(clkout), 0);
        chk("async_tick", int'(tick), 0);
        chk("async_pending", int'(pending), 0);
        step(2);
        reset = 1'b1; t0 = cyc;
        wait_tick(0, at);
        chk("post_rst_rise_8", at - t0, 8);
        chk("post_rst_ch1_tick", int'(tick[1]), 1);
        step(40);
        chk("post_rst_per0", per[0], 16);
        chk("post_rst_per1", per[1], 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
